// File: rtl/imr_pl_revision_axil_regs_if.sv
`default_nettype none
// ============================================================================
// Interface : imr_pl_revision_axil_regs_if
// Purpose   : AXI4-Lite signal bundle between the bus master and the IMR PL
//             revision register bank.
// Modports  : master - drives AW/W/AR payload + VALIDs, BREADY, RREADY
//             slave  - drives AWREADY, WREADY, B channel, ARREADY, R channel
// Revision  : 1.0 - initial release
// ============================================================================
interface imr_pl_revision_axil_regs_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  // Write address channel
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  // Write data channel
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  // Write response channel
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  // Read data channel
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface
`default_nettype wire

// File: rtl/imr_pl_revision_axil_regs.sv
`default_nettype none
// ============================================================================
// Module    : imr_pl_revision_axil_regs
// Purpose   : AXI4-Lite slave register bank for the IMR PL revision block.
//             0x00-0x0C REG0-REG3 (RW, byte strobed), 0x10 REVISION (RO),
//             0x14 BUILD (RO), 0x18 WR_COUNT (RO), 0x1C unmapped (reads 0).
//             One outstanding write and one outstanding read; the write and
//             read paths are independent state machines.
// Ports     : ACLK     - clock, rising edge
//             ARESETN  - asynchronous active-low reset
//             s_axi    - AXI4-Lite slave modport (AW/W/B/AR/R channels)
//             CTRL_OUT - live copy of REG3 (0x0C) for fabric logic
// Options   : define IMR_REV_WR_ERR_EN to answer writes to 0x10-0x1C and
//             reads of 0x1C with SLVERR; otherwise those writes are dropped
//             with OKAY and every read answers OKAY.
// Revision  : 1.0 - initial release
// ============================================================================
module imr_pl_revision_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,  // only 32 is supported
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] P_REVISION         = 32'h0001_0000,
  parameter logic [31:0] P_BUILD_ID         = 32'h0000_0000
) (
  input  wire                            ACLK,
  input  wire                            ARESETN,
  imr_pl_revision_axil_regs_if.slave     s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  CTRL_OUT
);

  localparam int         DW          = C_S_AXI_DATA_WIDTH;
  localparam int         AW          = C_S_AXI_ADDR_WIDTH;
  localparam int         SW          = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];
  logic [31:0]   wr_count_q, wr_count_d;

  // --------------------------------------------------------------------------
  // Write path state
  // --------------------------------------------------------------------------
  wstate_e       wstate_q, wstate_d;
  logic          aw_held_q, aw_held_d;
  logic          w_held_q, w_held_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;

  logic          aw_hs;
  logic          w_hs;
  logic          wr_fire;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_data;
  logic [SW-1:0] eff_strb;

  assign aw_hs = awready_q & s_axi.S_AXI_AWVALID;
  assign w_hs  = wready_q  & s_axi.S_AXI_WVALID;

  // The second channel to arrive is used straight off the bus so the update
  // lands on the very edge where both halves are in hand.
  assign eff_addr = aw_held_q ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign eff_data = w_held_q  ? wdata_q  : s_axi.S_AXI_WDATA;
  assign eff_strb = w_held_q  ? wstrb_q  : s_axi.S_AXI_WSTRB;

  assign wr_fire = (wstate_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);

  always_comb begin
    wstate_d   = wstate_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_count_d = wr_count_q;
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (wstate_q)
      W_IDLE: begin
        // READY comes up on the first edge out of reset and drops the cycle
        // after its own channel is captured.
        awready_d = ~(aw_held_q | aw_hs);
        wready_d  = ~(w_held_q | w_hs);
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if (wr_fire) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = RESP_OKAY;
          wstate_d   = W_RESP;
          wr_count_d = wr_count_q + 32'd1;
          if (!eff_addr[4]) begin
            for (int b = 0; b < SW; b++) begin
              if (eff_strb[b]) begin
                regs_d[eff_addr[3:2]][8*b +: 8] = eff_data[8*b +: 8];
              end
            end
          end
`ifdef IMR_REV_WR_ERR_EN
          else begin
            bresp_d = RESP_SLVERR;
          end
`endif
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: begin
        wstate_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q   <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_count_q <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wstate_q   <= wstate_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_count_q <= wr_count_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  rstate_e       rstate_q, rstate_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  logic          ar_hs;
  logic [DW-1:0] rd_mux;
  logic [1:0]    rd_resp;

  assign ar_hs = arready_q & s_axi.S_AXI_ARVALID;

  // Reads sample the registered bank, so a write landing on the same edge is
  // not yet visible: the read returns the pre-write value.
  always_comb begin
    rd_mux  = '0;
    rd_resp = RESP_OKAY;
    case (s_axi.S_AXI_ARADDR[4:2])
      3'd0:    rd_mux = regs_q[0];
      3'd1:    rd_mux = regs_q[1];
      3'd2:    rd_mux = regs_q[2];
      3'd3:    rd_mux = regs_q[3];
      3'd4:    rd_mux = P_REVISION;
      3'd5:    rd_mux = P_BUILD_ID;
      3'd6:    rd_mux = wr_count_q;
      default: begin
        rd_mux = '0;
`ifdef IMR_REV_WR_ERR_EN
        rd_resp = RESP_SLVERR;
`else
        rd_resp = RESP_OKAY;
`endif
      end
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_mux;
          rresp_d   = rd_resp;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: begin
        rstate_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign CTRL_OUT            = regs_q[3];

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       eff_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_imr_pl_revision_axil_regs.sv
`default_nettype none
// ============================================================================
// Module    : tb_imr_pl_revision_axil_regs
// Purpose   : Directed self-checking bench for imr_pl_revision_axil_regs.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_imr_pl_revision_axil_regs;

  logic        ACLK    = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] CTRL_OUT;

  int checks = 0;
  int errors = 0;

`ifdef IMR_REV_WR_ERR_EN
  localparam logic [1:0] EXP_HI_RESP = 2'b10;
`else
  localparam logic [1:0] EXP_HI_RESP = 2'b00;
`endif

  imr_pl_revision_axil_regs_if axi ();

  imr_pl_revision_axil_regs dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .s_axi    (axi),
    .CTRL_OUT (CTRL_OUT)
  );

  always #5 ACLK = ~ACLK;

  // --------------------------------------------------------------------------
  // Bus tasks
  // --------------------------------------------------------------------------
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           input int b_stall, output logic [1:0] resp);
    int c;
    bit aw_done, w_done, aw_hs, w_hs;
    c = 0; aw_done = 0; w_done = 0; resp = 2'b11;
    @(negedge ACLK);
    axi.S_AXI_AWADDR = addr;
    axi.S_AXI_WDATA  = data;
    axi.S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && c < 40) begin
      axi.S_AXI_WVALID  = !w_done;
      axi.S_AXI_AWVALID = !aw_done && (c >= w_lead);
      aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(negedge ACLK);
      c++;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL wr_handshake_timeout addr=%h: aw_done=%0d w_done=%0d required 1 1", addr, aw_done, w_done);
      return;
    end
    checks++;
    if (axi.S_AXI_BVALID !== 1'b1) begin
      errors++;
      $display("FAIL wr_latency addr=%h: BVALID=%b required 1", addr, axi.S_AXI_BVALID);
    end
    for (int i = 0; i < b_stall; i++) begin
      checks++;
      if ({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 3'b100) begin
        errors++;
        $display("FAIL b_stall cycle %0d: BVALID/AWREADY/WREADY=%b required 100", i,
                 {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
      end
      @(negedge ACLK);
    end
    c = 0;
    while (axi.S_AXI_BVALID !== 1'b1 && c < 40) begin
      @(negedge ACLK);
      c++;
    end
    if (axi.S_AXI_BVALID !== 1'b1) begin
      checks++; errors++;
      $display("FAIL bvalid_timeout addr=%h: BVALID=%b required 1", addr, axi.S_AXI_BVALID);
      return;
    end
    axi.S_AXI_BREADY = 1'b1;
    resp = axi.S_AXI_BRESP;
    @(negedge ACLK);
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int c;
    c = 0; data = 32'hxxxx_xxxx; resp = 2'b11;
    @(negedge ACLK);
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    while (axi.S_AXI_ARREADY !== 1'b1 && c < 40) begin
      @(negedge ACLK);
      c++;
    end
    if (axi.S_AXI_ARREADY !== 1'b1) begin
      checks++; errors++;
      axi.S_AXI_ARVALID = 1'b0;
      $display("FAIL arready_timeout addr=%h: ARREADY=%b required 1", addr, axi.S_AXI_ARREADY);
      return;
    end
    @(negedge ACLK);
    axi.S_AXI_ARVALID = 1'b0;
    checks++;
    if (axi.S_AXI_RVALID !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency addr=%h: RVALID=%b required 1", addr, axi.S_AXI_RVALID);
    end
    axi.S_AXI_RREADY = 1'b1;
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    @(negedge ACLK);
    axi.S_AXI_RREADY = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [41:0] outs;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    outs = {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID, axi.S_AXI_BRESP,
            axi.S_AXI_ARREADY, axi.S_AXI_RVALID, axi.S_AXI_RRESP, CTRL_OUT};
    checks++;
    if (outs !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    checks++;
    if (axi.S_AXI_RDATA !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h required 0", axi.S_AXI_RDATA);
    end
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    checks++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY,
         axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 5'b11100) begin
      errors++;
      $display("FAIL idle_readies: AWREADY/WREADY/ARREADY/BVALID/RVALID=%b required 11100",
               {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY,
                axi.S_AXI_BVALID, axi.S_AXI_RVALID});
    end
  endtask

  task automatic test_basic_rw();
    logic [1:0]  resp;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, resp);
      checks++;
      if (resp !== 2'b00) begin
        errors++;
        $display("FAIL basic_bresp reg%0d: got %b required 00", i, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, resp);
      checks++;
      if ({d, resp} !== {32'(i + 1), 2'b00}) begin
        errors++;
        $display("FAIL basic_read reg%0d: got %h/%b required %h/00", i, d, resp, 32'(i + 1));
      end
    end
    checks++;
    if (CTRL_OUT !== 32'd4) begin
      errors++;
      $display("FAIL ctrl_out: got %h required 00000004", CTRL_OUT);
    end
    axi_read(5'h18, d, resp);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL wr_count_4: got %h required 00000004", d);
    end
  endtask

  task automatic test_strobe();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(5'h04, 32'h1111_1111, 4'hF, 0, 0, resp);
    axi_write(5'h04, 32'hAABB_CCDD, 4'b0010, 0, 0, resp);
    axi_read(5'h04, d, resp);
    checks++;
    if (d !== 32'h1111_CC11) begin
      errors++;
      $display("FAIL strobe_lane1: got %h required 1111cc11", d);
    end
  endtask

  task automatic test_ro();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_read(5'h10, d, resp);
    checks++;
    if ({d, resp} !== {32'h0001_0000, 2'b00}) begin
      errors++;
      $display("FAIL revision: got %h/%b required 00010000/00", d, resp);
    end
    axi_read(5'h14, d, resp);
    checks++;
    if (d !== 32'h0000_0000) begin
      errors++;
      $display("FAIL build_id: got %h required 00000000", d);
    end
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    checks++;
    if (resp !== EXP_HI_RESP) begin
      errors++;
      $display("FAIL ro_write_bresp: got %b required %b", resp, EXP_HI_RESP);
    end
    axi_read(5'h10, d, resp);
    checks++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL revision_after_write: got %h required 00010000", d);
    end
    axi_read(5'h1C, d, resp);
    checks++;
    if ({d, resp} !== {32'h0, EXP_HI_RESP}) begin
      errors++;
      $display("FAIL unmapped_read: got %h/%b required 00000000/%b", d, resp, EXP_HI_RESP);
    end
  endtask

  task automatic test_w_before_aw_bstall();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(5'h08, 32'hDEAD_BEEF, 4'hF, 3, 10, resp);
    checks++;
    if (resp !== 2'b00) begin
      errors++;
      $display("FAIL w_first_bresp: got %b required 00", resp);
    end
    axi_read(5'h08, d, resp);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL w_first_data: got %h required deadbeef", d);
    end
    axi_read(5'h18, d, resp);
    checks++;
    if (d !== 32'd8) begin
      errors++;
      $display("FAIL wr_count_8: got %h required 00000008", d);
    end
    // WSTRB=0 completes OKAY, counts, and leaves the target untouched
    axi_write(5'h04, 32'hFFFF_FFFF, 4'h0, 0, 0, resp);
    axi_read(5'h04, d, resp);
    checks++;
    if (d !== 32'h1111_CC11) begin
      errors++;
      $display("FAIL strobe_zero: got %h required 1111cc11", d);
    end
    axi_read(5'h18, d, resp);
    checks++;
    if (d !== 32'd9) begin
      errors++;
      $display("FAIL wr_count_9: got %h required 00000009", d);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0]  wresp, rresp;
    logic [31:0] d;
    fork
      axi_write(5'h00, 32'd5, 4'hF, 0, 0, wresp);
      axi_read(5'h00, d, rresp);
    join
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL same_cycle_old: got %h required 00000001", d);
    end
    axi_read(5'h00, d, rresp);
    checks++;
    if (d !== 32'd5) begin
      errors++;
      $display("FAIL same_cycle_new: got %h required 00000005", d);
    end
    axi_read(5'h18, d, rresp);
    checks++;
    if (d !== 32'd10) begin
      errors++;
      $display("FAIL wr_count_10: got %h required 0000000a", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  resp;
    logic [31:0] d;
    logic [41:0] outs;
    @(negedge ACLK);
    axi.S_AXI_AWADDR  = 5'h08;
    axi.S_AXI_WDATA   = 32'h77;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b0;
    @(negedge ACLK);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    checks++;
    if ({axi.S_AXI_BVALID, CTRL_OUT} !== {1'b1, 32'd4}) begin
      errors++;
      $display("FAIL mid_pre_reset: BVALID/CTRL_OUT=%b/%h required 1/00000004",
               axi.S_AXI_BVALID, CTRL_OUT);
    end
    @(posedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    outs = {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID, axi.S_AXI_BRESP,
            axi.S_AXI_ARREADY, axi.S_AXI_RVALID, axi.S_AXI_RRESP, CTRL_OUT};
    checks++;
    if ({outs, axi.S_AXI_RDATA} !== 74'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h/%h required 0/0", outs, axi.S_AXI_RDATA);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    axi_read(5'h08, d, resp);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reg2_after_reset: got %h required 00000000", d);
    end
    axi_read(5'h18, d, resp);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL wr_count_after_reset: got %h required 00000000", d);
    end
  endtask

  initial begin
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWPROT  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARPROT  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;

    test_reset();
    test_basic_rw();
    test_strobe();
    test_ro();
    test_w_before_aw_bstall();
    test_same_cycle();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
